// File: rtl/sudoku_uart_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_uart_pkg
// Shared definitions for the sudoku accelerator's UART receive and transmit
// sides: FSM state encodings, frame geometry, the minimum bit divisor and a
// parity helper.
// -----------------------------------------------------------------------------
package sudoku_uart_pkg;

  localparam int DATA_BITS = 8;
  // Smallest usable clocks-per-bit; smaller clk_div values are clamped to it.
  localparam int MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Parity bit a correct frame carries: even parity when odd=0, odd when odd=1.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sudoku_uart_rx_if.sv
// -----------------------------------------------------------------------------
// sudoku_uart_rx_if
// Consumer-side handshake of the UART receiver.
//   rx_data    head byte of the receive FIFO
//   rx_valid   FIFO non-empty
//   rx_ready   consumer pops the head when rx_valid & rx_ready
//   fifo_level number of bytes held
// master: the receiver. slave: the consumer (accelerator).
// -----------------------------------------------------------------------------
interface sudoku_uart_rx_if
  import sudoku_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [LEVEL_W-1:0]   fifo_level;

  modport master (output rx_data, output rx_valid, output fifo_level, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input fifo_level, output rx_ready);

endinterface

// File: rtl/sudoku_rx_fifo.sv
// -----------------------------------------------------------------------------
// sudoku_rx_fifo
// Synchronous show-ahead FIFO: rd_data always presents the head entry.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_data     write request and byte
//   pop                 read request (gated internally by empty)
//   rd_data             head entry
//   full, empty, level  occupancy status; level = wr_ptr - rd_ptr
// -----------------------------------------------------------------------------
module sudoku_rx_fifo
  import sudoku_uart_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = DATA_BITS,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra MSB so full and empty stay distinguishable.
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its neighbours, independent of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is cleared too because the show-ahead head is a
      // visible output that must read 0 out of reset, not X.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + LVL_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sudoku_uart_rx.sv
// -----------------------------------------------------------------------------
// sudoku_uart_rx
// 8N1 UART receive front-end for the sudoku accelerator's serial channel.
// Synchronises ser_rx, times bits with a runtime divisor, validates start and
// stop bits and pushes good bytes into a show-ahead FIFO drained over rx_bus.
// Ports:
//   wb_clk_i     system clock (only clock)
//   wb_rst_n_i   synchronous reset, active low
//   enable       receiver enable; low forces IDLE, FIFO and flags kept
//   clk_div      clocks per bit, values < 2 act as 2, captured per frame
//   ser_rx       raw serial line, idle high
//   rx_bus       master side: rx_data / rx_valid / rx_ready / fifo_level
//   rx_active    FSM not in IDLE
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: byte dropped because the FIFO was full
//   err_clr      clears the sticky flags (a coincident new error wins)
//   irq          rx_valid | sticky flags
// Optional feature, macro SUDOKU_UART_RX_PARITY_EN: adds a parity bit after
// bit 7, input parity_odd and sticky output parity_err (also in irq). Bytes
// with bad parity are still delivered.
// -----------------------------------------------------------------------------
module sudoku_uart_rx
  import sudoku_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             ser_rx,
  sudoku_uart_rx_if.master rx_bus,
  output logic             rx_active,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr,
`ifdef SUDOKU_UART_RX_PARITY_EN
  input  logic             parity_odd,
  output logic             parity_err,
`endif
  output logic             irq
);

  localparam int               LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic                   line_prev_q;
  logic                   line_fall;

  uart_state_e            state_q;
  logic [DIV_W-1:0]       div_eff;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic                   tick;

  logic                   push;
  logic                   pop_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LEVEL_W-1:0]     level;
  logic                   frame_set;
  logic                   overrun_set;

  // ---------------------------------------------------------------------------
  // Line synchroniser, preset to idle-high so reset never looks like a start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      sync_q      <= '1;
      line_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ser_rx};
      line_prev_q <= line;
    end
  end

  assign line      = sync_q[SYNC_STAGES-1];
  assign line_fall = line_prev_q & ~line;
  assign div_eff   = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;
  assign tick      = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Receive FSM. The counter counts down to a sample point; after each sample
  // it reloads with div-1 so consecutive samples are exactly div clocks apart.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      div_q     <= DIV_MIN;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else if (!enable) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (line_fall) begin
            state_q <= ST_START;
            div_q   <= div_eff;
            cnt_q   <= div_eff >> 1;
          end
        end
        ST_START: begin
          if (tick) begin
            // A line back high at mid-start is a glitch: drop it silently.
            if (line) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              cnt_q     <= div_q - DIV_ONE;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - DIV_ONE;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q   <= {line, shift_q[DATA_BITS-1:1]};
            cnt_q     <= div_q - DIV_ONE;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == LAST_BIT) begin
`ifdef SUDOKU_UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - DIV_ONE;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            cnt_q   <= div_q - DIV_ONE;
          end else begin
            cnt_q <= cnt_q - DIV_ONE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_q <= line ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_q <= cnt_q - DIV_ONE;
          end
        end
        ST_BREAK: begin
          // Hold here until the line recovers so a stuck-low line reports once.
          if (line) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_active = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // FIFO and error flags
  // ---------------------------------------------------------------------------
  assign push      = enable & (state_q == ST_STOP) & tick & line;
  assign frame_set = enable & (state_q == ST_STOP) & tick & ~line;
  assign pop_ok    = rx_bus.rx_ready & ~fifo_empty;
  // A pop in the same cycle frees the slot, so only push-without-pop is lost.
  assign overrun_set = push & fifo_full & ~pop_ok;

  sudoku_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (push),
    .push_data (shift_q),
    .pop       (rx_bus.rx_ready),
    .rd_data   (rx_bus.rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign rx_bus.rx_valid   = ~fifo_empty;
  assign rx_bus.fifo_level = level;

`ifdef SUDOKU_UART_RX_PARITY_EN
  logic parity_set;
  assign parity_set = enable & (state_q == ST_PARITY) & tick &
                      (line != calc_parity(shift_q, parity_odd));
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SUDOKU_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (frame_set)        frame_err <= 1'b1;
      else if (err_clr)     frame_err <= 1'b0;
      if (overrun_set)      overrun   <= 1'b1;
      else if (err_clr)     overrun   <= 1'b0;
`ifdef SUDOKU_UART_RX_PARITY_EN
      if (parity_set)       parity_err <= 1'b1;
      else if (err_clr)     parity_err <= 1'b0;
`endif
    end
  end

`ifdef SUDOKU_UART_RX_PARITY_EN
  assign irq = rx_bus.rx_valid | frame_err | overrun | parity_err;
`else
  assign irq = rx_bus.rx_valid | frame_err | overrun;
`endif

endmodule

// File: tb/tb_sudoku_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_sudoku_uart_rx
// Directed bench for sudoku_uart_rx: clean byte, start glitch, framing error
// with a held-low line, overrun, simultaneous push/pop at full, enable drop,
// mid-frame reset and (with SUDOKU_UART_RX_PARITY_EN) a parity error.
// Inputs change on the falling clock edge; a monitor samples 1 ns later.
// -----------------------------------------------------------------------------
module tb_sudoku_uart_rx;
  import sudoku_uart_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             enable  = 1'b0;
  logic             ser_rx  = 1'b1;
  logic             err_clr = 1'b0;
  logic [DIV_W-1:0] clk_div = 16'd4;
  logic             rx_active;
  logic             frame_err;
  logic             overrun;
  logic             irq;
`ifdef SUDOKU_UART_RX_PARITY_EN
  logic             parity_odd = 1'b0;
  logic             parity_err;
`endif

  int         checks   = 0;
  int         errors   = 0;
  logic [7:0] pop_q[$];
  logic       active_seen = 1'b0;
  int         fe_rises    = 0;
  logic       fe_prev     = 1'b0;

  sudoku_uart_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) rx_bus ();

  sudoku_uart_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DIV_W       (DIV_W),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .enable     (enable),
    .clk_div    (clk_div),
    .ser_rx     (ser_rx),
    .rx_bus     (rx_bus),
    .rx_active  (rx_active),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
`ifdef SUDOKU_UART_RX_PARITY_EN
    .parity_odd (parity_odd),
    .parity_err (parity_err),
`endif
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Records every accepted pop and watches rx_active / frame_err edges.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && rx_bus.rx_valid && rx_bus.rx_ready) pop_q.push_back(rx_bus.rx_data);
    if (rx_active) active_seen = 1'b1;
    if (frame_err && !fe_prev) fe_rises++;
    fe_prev = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame LSB first; par_bit < 0 means no parity bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int par_bit);
    int bc;
    bc = int'(clk_div);
    ser_rx = 1'b0;
    wait_cycles(bc);
    for (int i = 0; i < 8; i++) begin
      ser_rx = data[i];
      wait_cycles(bc);
    end
    if (par_bit >= 0) begin
      ser_rx = par_bit[0];
      wait_cycles(bc);
    end
    ser_rx = stop_bit;
    wait_cycles(bc);
  endtask

  task automatic line_idle(input int n);
    ser_rx = 1'b1;
    wait_cycles(n);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    wait_cycles(1);
  endtask

  task automatic drain(input int n);
    rx_bus.rx_ready = 1'b1;
    wait_cycles(n);
    rx_bus.rx_ready = 1'b0;
    wait_cycles(1);
  endtask

  // Expects the logged pops to be the consecutive bytes first .. first+n-1.
  task automatic check_pops(input string tag, input int first, input int n);
    check({tag, "_count"}, pop_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < pop_q.size()) ? pop_q[i] : 8'hxx,
            8'(first + i));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, rx_bus.rx_valid, 0);
    check({tag, "_data"}, rx_bus.rx_data, 0);
    check({tag, "_level"}, rx_bus.fifo_level, 0);
    check({tag, "_active"}, rx_active, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    rx_bus.rx_ready = 1'b0;
    enable = 1'b1;
    wait_cycles(4);
    check_cleared("reset");
    rst_n = 1'b1;
    wait_cycles(4);

    // Clean 0xA5 at 4 clocks per bit, consumer always ready.
    rx_bus.rx_ready = 1'b1;
    pop_q.delete();
    send_frame(8'hA5, 1'b1, -1);
    line_idle(12);
    check("a5_count", pop_q.size(), 1);
    check("a5_data", (pop_q.size() > 0) ? pop_q[0] : 8'hxx, 8'hA5);
    check("a5_flags", {frame_err, overrun}, 2'b00);
    check("a5_level", rx_bus.fifo_level, 0);

    // One-clock low glitch at 8 clocks per bit.
    clk_div = 16'd8;
    active_seen = 1'b0;
    pop_q.delete();
    ser_rx = 1'b0;
    wait_cycles(1);
    line_idle(40);
    check("glitch_started", active_seen, 1);
    check("glitch_idle", rx_active, 0);
    check("glitch_pops", pop_q.size(), 0);
    check("glitch_flags", {frame_err, overrun}, 2'b00);
    clk_div = 16'd4;

    // 0x3C with a low stop bit, line then held low for 40 bit times.
    fe_rises = 0;
    send_frame(8'h3C, 1'b0, -1);
    wait_cycles(40 * 4);
    check("break_frame_err", frame_err, 1);
    check("break_active", rx_active, 1);
    check("break_level", rx_bus.fifo_level, 0);
    check("break_irq", irq, 1);
    line_idle(20);
    check("break_once", fe_rises, 1);
    check("break_recovered", rx_active, 0);
    check("break_pops", pop_q.size(), 0);
    pulse_err_clr();
    check("break_clr", frame_err, 0);
    check("break_clr_irq", irq, 0);

    // Nine bytes with the consumer stalled: the ninth is dropped.
    rx_bus.rx_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      send_frame(8'(b), 1'b1, -1);
      line_idle(8);
    end
    check("ovr_level", rx_bus.fifo_level, 8);
    check("ovr_flag", overrun, 1);
    check("ovr_head", rx_bus.rx_data, 8'h01);
    pop_q.delete();
    drain(12);
    check_pops("ovr_pop", 1, 8);
    check("ovr_empty_level", rx_bus.fifo_level, 0);
    pulse_err_clr();
    check("ovr_clr", overrun, 0);

    // Full FIFO, pop lands on the exact push cycle of the ninth byte.
    // Push happens on the 42nd rising edge after the start bit is driven.
    for (int b = 1; b <= 8; b++) begin
      send_frame(8'(b), 1'b1, -1);
      line_idle(8);
    end
    check("full_level", rx_bus.fifo_level, 8);
    pop_q.delete();
    send_frame(8'h09, 1'b1, -1);
    wait_cycles(1);
    rx_bus.rx_ready = 1'b1;
    wait_cycles(1);
    rx_bus.rx_ready = 1'b0;
    check("same_level", rx_bus.fifo_level, 8);
    check("same_overrun", overrun, 0);
    check_pops("same_first", 1, 1);
    line_idle(4);
    pop_q.delete();
    drain(12);
    check_pops("same_drain", 2, 8);

    // Enable dropped mid-frame forces IDLE on the next cycle.
    ser_rx = 1'b0;
    wait_cycles(8);
    check("en_active", rx_active, 1);
    enable = 1'b0;
    wait_cycles(1);
    check("en_forced_idle", rx_active, 0);
    line_idle(40);
    enable = 1'b1;
    wait_cycles(4);
    check("en_level", rx_bus.fifo_level, 0);
    check("en_flags", {frame_err, overrun}, 2'b00);

    // Reset in the middle of a 0xFF frame with one byte already queued.
    send_frame(8'h77, 1'b1, -1);
    line_idle(8);
    check("pre_rst_head", rx_bus.rx_data, 8'h77);
    ser_rx = 1'b0;
    wait_cycles(4);
    ser_rx = 1'b1;
    wait_cycles(8);
    check("pre_rst_active", rx_active, 1);
    rst_n = 1'b0;
    wait_cycles(2);
    check_cleared("mid_rst");
    rst_n = 1'b1;
    line_idle(40);
    pop_q.delete();
    rx_bus.rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, -1);
    line_idle(12);
    rx_bus.rx_ready = 1'b0;
    check("post_rst_count", pop_q.size(), 1);
    check("post_rst_data", (pop_q.size() > 0) ? pop_q[0] : 8'hxx, 8'h5A);
    check("post_rst_flags", {frame_err, overrun}, 2'b00);

`ifdef SUDOKU_UART_RX_PARITY_EN
    // Even parity expected; 0x07 has three ones, so parity bit 0 is wrong.
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 0);
    line_idle(12);
    check("par_err", parity_err, 1);
    check("par_level", rx_bus.fifo_level, 1);
    check("par_data", rx_bus.rx_data, 8'h07);
    check("par_frame_err", frame_err, 0);
    pulse_err_clr();
    check("par_clr", parity_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
